muldiv_seq: RTL

//   Parametrised multicycle multiply/divide unit for the multicycle datapath.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_signfix.sv | 14 +
 rtl/muldiv_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multicycle multiply/divide engine.
// Holds the op codes, the FSM state codes and the counter sizing helpers.
// Optional macro used by muldiv_seq: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Counter width for a given operand width; it must hold WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement of an N-bit value (purely combinational).
// Used to take magnitudes at load time and to restore result signs.
// Negating the most negative value returns it unchanged, which is what callers expect.
module muldiv_signfix #(
  parameter int N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] val,
  output logic [N-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_seq.sv
// Multicycle signed/unsigned multiply and divide unit writing HI/LO.
// Latency WIDTH+2 cycles from the start cycle; divide by zero reports in 1 cycle.
// Configuration macro MULDIV_EARLY_OUT_EN: multiply stops once the multiplier runs out of ones.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = cnt_width(WIDTH);

  state_t         state;
  logic           is_div;
  logic           sign_a;
  logic           sign_b;
  logic [CW-1:0]  cnt;
  // Multiply: running product. Divide: {remainder, quotient/dividend}.
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  // Multiply: shifting multiplier. Divide: divisor magnitude.
  logic [W-1:0]   mplier;

  logic           signed_op;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;

  logic [2*W-1:0] mul_sum;
  logic [W:0]     div_sh;
  logic           div_ok;
  logic [W-1:0]   div_rem;
  logic [W-1:0]   div_quot;
  logic           last_step;

  assign busy      = (state != S_IDLE);
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[W-1];
  assign b_neg     = signed_op & b[W-1];

  muldiv_signfix #(.N(W))   u_abs_a (.neg(a_neg),           .val(a),             .res(abs_a));
  muldiv_signfix #(.N(W))   u_abs_b (.neg(b_neg),           .val(b),             .res(abs_b));
  muldiv_signfix #(.N(2*W)) u_prod  (.neg(sign_a ^ sign_b), .val(acc),           .res(prod_fix));
  muldiv_signfix #(.N(W))   u_quot  (.neg(sign_a ^ sign_b), .val(acc[W-1:0]),    .res(quot_fix));
  muldiv_signfix #(.N(W))   u_rem   (.neg(sign_a),          .val(acc[2*W-1:W]),  .res(rem_fix));

  // One shift-add or restoring-divide step, plus the CALC exit condition.
  always_comb begin
    mul_sum  = mplier[0] ? (acc + mcand) : acc;
    div_sh   = {acc[2*W-1:W], acc[W-1]};
    div_ok   = (div_sh >= {1'b0, mplier});
    div_rem  = div_ok ? W'(div_sh - {1'b0, mplier}) : div_sh[W-1:0];
    div_quot = {acc[W-2:0], div_ok};
`ifdef MULDIV_EARLY_OUT_EN
    last_step = (cnt == '0) || (!is_div && (mplier[W-1:1] == '0));
`else
    last_step = (cnt == '0);
`endif
  end

  // Control FSM and datapath registers with registered done/div_zero/hi/lo.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op[1] && (b == '0)) begin
              // Divide by zero: flag it at once, leave hi/lo alone.
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              is_div   <= op[1];
              sign_a   <= a_neg;
              sign_b   <= b_neg;
              div_zero <= 1'b0;
              cnt      <= CW'(W - 1);
              mcand    <= {{W{1'b0}}, abs_a};
              mplier   <= abs_b;
              acc      <= op[1] ? {{W{1'b0}}, abs_a} : '0;
              state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (is_div) begin
            acc <= {div_rem, div_quot};
          end else begin
            acc    <= mul_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          cnt <= cnt - CW'(1);
          if (last_step) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
